uart_to_morse: RTL and testbench

Consumes ASCII bytes from the receive FIFO side of the team's `uart` block (`r_data` / `rd_uart` / `rx_empty`) and plays each character as timed Morse code on a single output that drives an LED or buzzer. It is the terminal-to-board direction of the Morse/PuTTY link, complementing the button-to-terminal path. Letters (either case), digits and space are supported. Other bytes are dropped and flagged.

---
 rtl/uart_to_morse.sv | 167 ++++++++++++++++
 tb/tb_uart_to_morse.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_to_morse.sv
// Plays ASCII bytes popped from a first-word-fall-through UART receive FIFO
// as timed Morse code on a single mark/space output.
module uart_to_morse #(
  parameter int unsigned UNIT_TICKS = 5_000_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] r_data,
  input  logic       rx_empty,
  output logic       rd_uart,
  output logic       morse_out,
  output logic       busy,
  output logic       bad_char
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    MARK,
    ELEM_GAP,
    CHAR_GAP,
    WORD_GAP
  } state_t;

  localparam int unsigned   TW        = (UNIT_TICKS > 1) ? $clog2(UNIT_TICKS) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(UNIT_TICKS - 1);

  state_t        state, state_nx;
  logic [7:0]    char_q;
  logic [7:0]    ch_up;
  logic [TW-1:0] tick_cnt;
  logic [2:0]    unit_cnt;
  logic [2:0]    unit_target;
  logic [2:0]    idx;
  logic [2:0]    bit_pos;
  logic [2:0]    len;
  logic [4:0]    pat;
  logic          valid, is_space;
  logic          tick, elem_done, cur_dash, timed;

  // Character ROM: len elements, pattern left-aligned MSB-first, 1 = dash
  always_comb begin
    ch_up    = char_q;
    len      = '0;
    pat      = '0;
    valid    = 1'b1;
    is_space = 1'b0;
    if (char_q >= 8'h61 && char_q <= 8'h7A) ch_up = char_q - 8'h20;
    case (ch_up)
      8'h20: is_space = 1'b1;
      8'h41: {len, pat} = {3'd2, 5'b01000};
      8'h42: {len, pat} = {3'd4, 5'b10000};
      8'h43: {len, pat} = {3'd4, 5'b10100};
      8'h44: {len, pat} = {3'd3, 5'b10000};
      8'h45: {len, pat} = {3'd1, 5'b00000};
      8'h46: {len, pat} = {3'd4, 5'b00100};
      8'h47: {len, pat} = {3'd3, 5'b11000};
      8'h48: {len, pat} = {3'd4, 5'b00000};
      8'h49: {len, pat} = {3'd2, 5'b00000};
      8'h4A: {len, pat} = {3'd4, 5'b01110};
      8'h4B: {len, pat} = {3'd3, 5'b10100};
      8'h4C: {len, pat} = {3'd4, 5'b01000};
      8'h4D: {len, pat} = {3'd2, 5'b11000};
      8'h4E: {len, pat} = {3'd2, 5'b10000};
      8'h4F: {len, pat} = {3'd3, 5'b11100};
      8'h50: {len, pat} = {3'd4, 5'b01100};
      8'h51: {len, pat} = {3'd4, 5'b11010};
      8'h52: {len, pat} = {3'd3, 5'b01000};
      8'h53: {len, pat} = {3'd3, 5'b00000};
      8'h54: {len, pat} = {3'd1, 5'b10000};
      8'h55: {len, pat} = {3'd3, 5'b00100};
      8'h56: {len, pat} = {3'd4, 5'b00010};
      8'h57: {len, pat} = {3'd3, 5'b01100};
      8'h58: {len, pat} = {3'd4, 5'b10010};
      8'h59: {len, pat} = {3'd4, 5'b10110};
      8'h5A: {len, pat} = {3'd4, 5'b11000};
      8'h30: {len, pat} = {3'd5, 5'b11111};
      8'h31: {len, pat} = {3'd5, 5'b01111};
      8'h32: {len, pat} = {3'd5, 5'b00111};
      8'h33: {len, pat} = {3'd5, 5'b00011};
      8'h34: {len, pat} = {3'd5, 5'b00001};
      8'h35: {len, pat} = {3'd5, 5'b00000};
      8'h36: {len, pat} = {3'd5, 5'b10000};
      8'h37: {len, pat} = {3'd5, 5'b11000};
      8'h38: {len, pat} = {3'd5, 5'b11100};
      8'h39: {len, pat} = {3'd5, 5'b11110};
      default: valid = 1'b0;
    endcase
  end

  always_comb begin
    bit_pos  = 3'd4 - (len - 3'd1 - idx);
    cur_dash = pat[bit_pos];
    tick     = (tick_cnt == TICK_LAST);
    timed    = (state == MARK) || (state == ELEM_GAP) ||
               (state == CHAR_GAP) || (state == WORD_GAP);
    case (state)
      MARK:     unit_target = cur_dash ? 3'd3 : 3'd1;
      ELEM_GAP: unit_target = 3'd1;
      CHAR_GAP: unit_target = 3'd3;
      WORD_GAP: unit_target = 3'd4;
      default:  unit_target = 3'd1;
    endcase
    elem_done = tick && (unit_cnt == unit_target - 3'd1);
  end

  always_comb begin
    state_nx = state;
    rd_uart  = 1'b0;
    bad_char = 1'b0;
    case (state)
      IDLE:   if (!rx_empty) state_nx = FETCH;
      FETCH: begin
        rd_uart  = 1'b1;
        state_nx = DECODE;
      end
      DECODE: begin
        if (!valid) begin
          bad_char = 1'b1;
          state_nx = IDLE;
        end else if (is_space) begin
          state_nx = WORD_GAP;
        end else begin
          state_nx = MARK;
        end
      end
      MARK:     if (elem_done) state_nx = (idx == 3'd0) ? CHAR_GAP : ELEM_GAP;
      ELEM_GAP: if (elem_done) state_nx = MARK;
      CHAR_GAP: if (elem_done) state_nx = IDLE;
      WORD_GAP: if (elem_done) state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      char_q    <= '0;
      tick_cnt  <= '0;
      unit_cnt  <= '0;
      idx       <= '0;
      morse_out <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nx;
      morse_out <= (state_nx == MARK);
      busy      <= (state_nx != IDLE);
      if (state == FETCH) char_q <= r_data;
      if (state == DECODE) idx <= len - 3'd1;
      else if (state == MARK && elem_done && idx != 3'd0) idx <= idx - 3'd1;
      // Any state change restarts timing so each element is a whole number of units
      if (state_nx != state) begin
        tick_cnt <= '0;
        unit_cnt <= '0;
      end else if (timed) begin
        if (tick) begin
          tick_cnt <= '0;
          unit_cnt <= unit_cnt + 3'd1;
        end else begin
          tick_cnt <= tick_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_to_morse.sv
// Self-checking bench for uart_to_morse: per-character summary table,
// cycle-exact trace comparison against a Morse-string reference model.
module tb_uart_to_morse;

  localparam int unsigned UT = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] r_data;
  logic       rx_empty;
  logic       rd_uart, morse_out, busy, bad_char;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [256];
  logic [7:0] wr_ptr = 8'd0;
  logic [7:0] rd_ptr = 8'd0;
  logic [7:0] stim [$];
  logic [3:0] exp_q [$];

  string letters [26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..",
                          ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.",
                          "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--.."};
  string digits [10] = '{"-----", ".----", "..---", "...--", "....-",
                         ".....", "-....", "--...", "---..", "----."};

  typedef struct packed {
    logic [7:0] c;
    logic [7:0] high;
    logic [7:0] busyc;
    logic       bad;
  } vec_t;
  vec_t vecs [16];

  always #5 clk = ~clk;

  assign rx_empty = (rd_ptr == wr_ptr);
  assign r_data   = mem[rd_ptr];

  uart_to_morse #(.UNIT_TICKS(UT)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .r_data   (r_data),
    .rx_empty (rx_empty),
    .rd_uart  (rd_uart),
    .morse_out(morse_out),
    .busy     (busy),
    .bad_char (bad_char)
  );

  // FIFO head advances just after the edge that ends the pop cycle
  always @(negedge clk) begin
    if (rd_uart) begin
      @(posedge clk);
      #1;
      rd_ptr = rd_ptr + 8'd1;
    end
  end

  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endfunction

  function automatic bit lookup(input logic [7:0] c, output string code);
    code = "";
    if (c == 8'h20) begin
      code = " ";
      return 1'b1;
    end
    if (c >= 8'h41 && c <= 8'h5A) begin code = letters[int'(c) - 65]; return 1'b1; end
    if (c >= 8'h61 && c <= 8'h7A) begin code = letters[int'(c) - 97]; return 1'b1; end
    if (c >= 8'h30 && c <= 8'h39) begin code = digits[int'(c) - 48];  return 1'b1; end
    return 1'b0;
  endfunction

  // Expected per-cycle {rd_uart, bad_char, morse_out, busy} for one character
  function automatic void model_char(input logic [7:0] c);
    string code;
    bit    ok;
    ok = lookup(c, code);
    exp_q.push_back(4'b1001);
    if (!ok) begin
      exp_q.push_back(4'b0101);
    end else if (code == " ") begin
      exp_q.push_back(4'b0001);
      repeat (4 * UT) exp_q.push_back(4'b0001);
    end else begin
      exp_q.push_back(4'b0001);
      for (int i = 0; i < code.len(); i++) begin
        repeat (((code[i] == 8'h2D) ? 3 : 1) * UT) exp_q.push_back(4'b0011);
        if (i != code.len() - 1) repeat (UT) exp_q.push_back(4'b0001);
      end
      repeat (3 * UT) exp_q.push_back(4'b0001);
    end
    exp_q.push_back(4'b0000);
  endfunction

  task automatic push_byte(input logic [7:0] c);
    mem[wr_ptr] = c;
    wr_ptr      = wr_ptr + 8'd1;
  endtask

  task automatic run_stim(input string tag);
    int         n;
    int         rd_seen;
    int         cyc;
    logic [3:0] e;
    logic [3:0] a;
    n       = stim.size();
    rd_seen = 0;
    cyc     = 0;
    foreach (stim[i]) begin
      push_byte(stim[i]);
      model_char(stim[i]);
    end
    stim.delete();
    while (exp_q.size() > 0) begin
      @(negedge clk);
      cyc++;
      e = exp_q.pop_front();
      a = {rd_uart, bad_char, morse_out, busy};
      chk($sformatf("%s@%0d", tag, cyc), int'(a), int'(e));
      if (rd_uart) begin
        rd_seen++;
        chk({tag, "_rx_nonempty_at_pop"}, int'(rx_empty), 0);
      end
    end
    chk({tag, "_pops"}, rd_seen, n);
  endtask

  task automatic measure(input logic [7:0] c, output int hi, output int bz,
                         output int bd, output int rd);
    hi = 0; bz = 0; bd = 0; rd = 0;
    push_byte(c);
    repeat (120) begin
      @(negedge clk);
      hi += int'(morse_out);
      bz += int'(busy);
      bd += int'(bad_char);
      rd += int'(rd_uart);
    end
  endtask

  function automatic logic [7:0] rand_char();
    case ($urandom_range(0, 4))
      0:       return 8'h41 + 8'($urandom_range(0, 25));
      1:       return 8'h61 + 8'($urandom_range(0, 25));
      2:       return 8'h30 + 8'($urandom_range(0, 9));
      3:       return 8'h20;
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  initial begin
    int hi, bz, bd, rd, act;

    vecs[0]  = '{8'h45, 8'd4,  8'd18, 1'b0};
    vecs[1]  = '{8'h61, 8'd16, 8'd34, 1'b0};
    vecs[2]  = '{8'h41, 8'd16, 8'd34, 1'b0};
    vecs[3]  = '{8'h7A, 8'd32, 8'd58, 1'b0};
    vecs[4]  = '{8'h5A, 8'd32, 8'd58, 1'b0};
    vecs[5]  = '{8'h54, 8'd12, 8'd26, 1'b0};
    vecs[6]  = '{8'h30, 8'd60, 8'd90, 1'b0};
    vecs[7]  = '{8'h39, 8'd52, 8'd82, 1'b0};
    vecs[8]  = '{8'h20, 8'd0,  8'd18, 1'b0};
    vecs[9]  = '{8'h23, 8'd0,  8'd2,  1'b1};
    vecs[10] = '{8'h40, 8'd0,  8'd2,  1'b1};
    vecs[11] = '{8'h5B, 8'd0,  8'd2,  1'b1};
    vecs[12] = '{8'h60, 8'd0,  8'd2,  1'b1};
    vecs[13] = '{8'h7B, 8'd0,  8'd2,  1'b1};
    vecs[14] = '{8'h2F, 8'd0,  8'd2,  1'b1};
    vecs[15] = '{8'h3A, 8'd0,  8'd2,  1'b1};

    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", int'({rd_uart, bad_char, morse_out, busy}), 0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_reset_idle", int'({rd_uart, bad_char, morse_out, busy}), 0);

    foreach (vecs[i]) begin
      measure(vecs[i].c, hi, bz, bd, rd);
      chk($sformatf("tbl_high_%02h", vecs[i].c), hi, int'(vecs[i].high));
      chk($sformatf("tbl_busy_%02h", vecs[i].c), bz, int'(vecs[i].busyc));
      chk($sformatf("tbl_bad_%02h", vecs[i].c), bd, int'(vecs[i].bad));
      chk($sformatf("tbl_pops_%02h", vecs[i].c), rd, 1);
    end

    stim = '{8'h45};
    run_stim("trace_E");
    stim = '{8'h61};
    run_stim("trace_a");
    stim = '{8'h35, 8'h20, 8'h30};
    run_stim("trace_5sp0");
    stim = '{8'h23, 8'h54};
    run_stim("trace_badT");

    act = 0;
    repeat (100) begin
      @(negedge clk);
      act |= int'({rd_uart, bad_char, morse_out, busy});
    end
    chk("empty_hold", act, 0);

    push_byte(8'h54);
    repeat (5) @(negedge clk);
    chk("t_dash_on", int'(morse_out), 1);
    #2 reset_n = 1'b0;
    #1 chk("async_reset_clear", int'({rd_uart, morse_out, busy}), 0);
    @(negedge clk);
    reset_n = 1'b1;
    act = 0;
    repeat (30) begin
      @(negedge clk);
      act |= int'({rd_uart, bad_char, morse_out, busy});
    end
    chk("post_reset_quiet", act, 0);
    stim = '{8'h4E};
    run_stim("trace_after_reset_N");

    for (int r = 0; r < 4; r++) begin
      for (int j = 0; j < 5; j++) stim.push_back(rand_char());
      run_stim($sformatf("rand%0d", r));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
